dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_arbiter2.sv | 34 +++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, depth and FSM encoding for the data-memory arbiter.
// Imported by the arbiter top and its round-robin grant unit.
package dmem_arbiter_pkg;

  localparam int DEF_WORD  = 64;
  localparam int DEF_DEPTH = 128;
  localparam int DEF_AW    = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDATA  = 2'd2
  } state_e;

  localparam logic OWN_P = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a last-grant flag.
// Bit 0 is the pipeline port, bit 1 the loader port.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // A lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    last_d = last_q;
    if (upd_i && (gnt_o != 2'b00))
      last_d = gnt_o[1];
  end

  // Reset as if the loader went last so the pipeline takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the pipeline and
// the loader port; one transaction at a time, round-robin on ties.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WORD  = DEF_WORD,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p_req,
  input  logic            p_we,
  input  logic [WORD-1:0] p_addr,
  input  logic [WORD-1:0] p_wdata,
  output logic            p_ready,
  output logic [WORD-1:0] p_rdata,
  output logic            p_err,
  output logic            p_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_ready,
  output logic [WORD-1:0] d_rdata,
  output logic            d_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata
);

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [WORD-4:0] idx_q, idx_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic [WORD-1:0] p_rdata_q, d_rdata_q;
  logic [1:0]      gnt;
  logic            oor;
  logic            done;
  logic            rd_fin;
  logic [WORD-1:0] rd_val;
  logic            unused_lsb;

  // Byte offset within a doubleword carries no information here.
  assign unused_lsb = ^{p_addr[2:0], d_addr[2:0]};

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({d_req, p_req}),
    .upd_i (state_q == S_IDLE),
    .gnt_o (gnt)
  );

  // Next state and winner capture; arbitration only happens in IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          state_d = S_ACCESS;
          owner_d = gnt[1];
          we_d    = gnt[1] ? d_we : p_we;
          idx_d   = gnt[1] ? d_addr[WORD-1:3] : p_addr[WORD-1:3];
          wdata_d = gnt[1] ? d_wdata : p_wdata;
        end
      end
      S_ACCESS: state_d = we_q ? S_IDLE : S_RDATA;
      S_RDATA:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, latched request and per-port read-data holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_P;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (rd_fin && owner_q == OWN_P) p_rdata_q <= rd_val;
      if (rd_fin && owner_q == OWN_D) d_rdata_q <= rd_val;
    end
  end

  assign oor    = idx_q >= (WORD-3)'(DEPTH);
  assign rd_fin = state_q == S_RDATA;
  assign done   = (state_q == S_ACCESS && we_q) || rd_fin;
  assign rd_val = oor ? '0 : mem_rdata;

  assign mem_en    = state_q == S_ACCESS && !oor;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = idx_q[AW-1:0];
  assign mem_wdata = wdata_q;

  assign p_ready = done && owner_q == OWN_P;
  assign d_ready = done && owner_q == OWN_D;
  assign p_err   = p_ready && oor;
  assign d_err   = d_ready && oor;
  assign p_stall = p_req && !p_ready;

  // Completing read shows memory data the same cycle, then holds it.
  assign p_rdata = (rd_fin && owner_q == OWN_P) ? rd_val : p_rdata_q;
  assign d_rdata = (rd_fin && owner_q == OWN_D) ? rd_val : d_rdata_q;

endmodule
